// File: rtl/ecp5_slave_serial_target.sv
// ecp5_slave_serial_target
// Target side of the ECP5 slave-serial configuration link. CCLK, DI and
// PROGRAMN are oversampled on i_clk. MSB-first bytes are rebuilt and handed
// to user logic. The trailing byte is checked against an 8-bit additive
// checksum. Once the image is accepted, wake-up clocks are counted before
// DONE is raised. A checksum mismatch is reported by holding INITN low.
module ecp5_slave_serial_target #(
   parameter int P_CONFIG_BYTES = 1024,
   parameter int P_INIT_CLKS    = 256,
   parameter int P_WAKEUP_EDGES = 1024
) (
   input  logic       i_clk,
   input  logic       i_arst,
   input  logic       i_mclk,
   input  logic       i_prog_n,
   input  logic       i_din,
   output logic       o_init_n,
   output logic       o_done,
   output logic       o_byte_vld,
   output logic [7:0] o_byte,
   output logic       o_byte_last,
   output logic       o_busy,
   output logic       o_cfg_err
);

   localparam int BYTE_W = (P_CONFIG_BYTES > 1) ? $clog2(P_CONFIG_BYTES) : 1;
   localparam int INIT_W = (P_INIT_CLKS > 1) ? $clog2(P_INIT_CLKS) : 1;
   localparam int WAKE_W = (P_WAKEUP_EDGES > 1) ? $clog2(P_WAKEUP_EDGES) : 1;

   localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(P_CONFIG_BYTES - 1);
   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(P_INIT_CLKS - 1);
   localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(P_WAKEUP_EDGES - 1);
   localparam logic [BYTE_W-1:0] BYTE_ONE  = BYTE_W'(1);
   localparam logic [INIT_W-1:0] INIT_ONE  = INIT_W'(1);
   localparam logic [WAKE_W-1:0] WAKE_ONE  = WAKE_W'(1);

   typedef enum logic [2:0] {
      PROG_LOW  = 3'd0,
      INIT_HOLD = 3'd1,
      RECEIVE   = 3'd2,
      WAKEUP    = 3'd3,
      DONE_ST   = 3'd4,
      ERROR     = 3'd5
   } state_t;

   state_t state_r;
   state_t fsm_next_s;
   state_t next_state_s;

   logic mclk_s1_r, mclk_s2_r, mclk_s3_r;
   logic din_s1_r, din_s2_r;
   logic prog_s1_r, prog_s2_r;

   logic [2:0]        bit_cnt_r;
   logic [BYTE_W-1:0] byte_cnt_r;
   logic [INIT_W-1:0] init_cnt_r;
   logic [WAKE_W-1:0] wake_cnt_r;
   logic [7:0]        sum_r;
   logic [6:0]        shift_r;

   logic       rise_s;
   logic [7:0] byte_s;
   logic       is_last_s;
   logic       fsm_emit_s;
   logic       emit_s;

   // Bring the asynchronous link pins into the i_clk domain; PROGRAMN idles high.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         mclk_s1_r <= 1'b0;
         mclk_s2_r <= 1'b0;
         mclk_s3_r <= 1'b0;
         din_s1_r  <= 1'b0;
         din_s2_r  <= 1'b0;
         prog_s1_r <= 1'b1;
         prog_s2_r <= 1'b1;
      end else begin
         mclk_s1_r <= i_mclk;
         mclk_s2_r <= mclk_s1_r;
         mclk_s3_r <= mclk_s2_r;
         din_s1_r  <= i_din;
         din_s2_r  <= din_s1_r;
         prog_s1_r <= i_prog_n;
         prog_s2_r <= prog_s1_r;
      end
   end

   assign rise_s    = mclk_s2_r & ~mclk_s3_r;
   assign byte_s    = {shift_r, din_s2_r};
   assign is_last_s = (byte_cnt_r == BYTE_LAST);

   // State register; reset lands directly in INIT_HOLD as on power-up.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state_r <= INIT_HOLD;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode; a low PROGRAMN wins over everything, including a completing byte.
   always_comb begin
      fsm_next_s = state_r;
      fsm_emit_s = 1'b0;
      case (state_r)
         PROG_LOW: begin
            fsm_next_s = INIT_HOLD;
         end
         INIT_HOLD: begin
            if (init_cnt_r == INIT_LAST) begin
               fsm_next_s = RECEIVE;
            end else begin
               fsm_next_s = INIT_HOLD;
            end
         end
         RECEIVE: begin
            if (rise_s && (bit_cnt_r == 3'd7)) begin
               fsm_emit_s = 1'b1;
               if (is_last_s) begin
                  if (byte_s == sum_r) begin
                     fsm_next_s = WAKEUP;
                  end else begin
                     fsm_next_s = ERROR;
                  end
               end else begin
                  fsm_next_s = RECEIVE;
               end
            end else begin
               fsm_next_s = RECEIVE;
            end
         end
         WAKEUP: begin
            if (rise_s && (wake_cnt_r == WAKE_LAST)) begin
               fsm_next_s = DONE_ST;
            end else begin
               fsm_next_s = WAKEUP;
            end
         end
         DONE_ST: begin
            fsm_next_s = DONE_ST;
         end
         ERROR: begin
            fsm_next_s = ERROR;
         end
         default: begin
            fsm_next_s = ERROR;
         end
      endcase
      next_state_s = prog_s2_r ? fsm_next_s : PROG_LOW;
      emit_s       = prog_s2_r & fsm_emit_s;
   end

   // Counters, shift register and running checksum; all discarded whenever PROGRAMN is low.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         bit_cnt_r  <= 3'd0;
         byte_cnt_r <= '0;
         init_cnt_r <= '0;
         wake_cnt_r <= '0;
         sum_r      <= 8'd0;
         shift_r    <= 7'd0;
      end else if (next_state_s == PROG_LOW) begin
         bit_cnt_r  <= 3'd0;
         byte_cnt_r <= '0;
         init_cnt_r <= '0;
         wake_cnt_r <= '0;
         sum_r      <= 8'd0;
         shift_r    <= 7'd0;
      end else begin
         case (state_r)
            INIT_HOLD: begin
               if (init_cnt_r != INIT_LAST) begin
                  init_cnt_r <= init_cnt_r + INIT_ONE;
               end
            end
            RECEIVE: begin
               if (rise_s) begin
                  shift_r   <= {shift_r[5:0], din_s2_r};
                  bit_cnt_r <= bit_cnt_r + 3'd1;
               end
               if (emit_s && !is_last_s) begin
                  byte_cnt_r <= byte_cnt_r + BYTE_ONE;
                  sum_r      <= sum_r + byte_s;
               end
            end
            WAKEUP: begin
               if (rise_s && (wake_cnt_r != WAKE_LAST)) begin
                  wake_cnt_r <= wake_cnt_r + WAKE_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Registered outputs decoded from the state being entered, so they change with the state.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         o_init_n    <= 1'b0;
         o_done      <= 1'b0;
         o_byte_vld  <= 1'b0;
         o_byte      <= 8'd0;
         o_byte_last <= 1'b0;
         o_busy      <= 1'b1;
         o_cfg_err   <= 1'b0;
      end else begin
         o_init_n    <= (next_state_s == RECEIVE) || (next_state_s == WAKEUP) ||
                        (next_state_s == DONE_ST);
         o_done      <= (next_state_s == DONE_ST);
         o_busy      <= (next_state_s == INIT_HOLD) || (next_state_s == RECEIVE) ||
                        (next_state_s == WAKEUP);
         o_cfg_err   <= (next_state_s == ERROR);
         o_byte_vld  <= emit_s;
         o_byte_last <= emit_s & is_last_s;
         if (emit_s) begin
            o_byte <= byte_s;
         end
      end
   end

endmodule
